rst_seq: RTL and testbench
==========================

RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL provide parameter NDOM, default 4, number of sequenced reset domains (2..8).
REQ-002 SHALL provide parameter LOCK_FILT, default 16, consecutive lock-high cycles required before sequencing starts.
REQ-003 SHALL provide parameter DLY, default 128, cycles per release stage (1..255).
REQ-004 SHALL provide parameter CAL_TO, default 1048576, cycles allowed for CALIB_DONE after domain 0 release.
REQ-005 SHALL have ports:
- CLK  in  1  system clock; the only clock.
- RST  in  1  reset, synchronous, active-high.
- LOCKED  in  1  PLL lock, asynchronous to CLK.
- CALIB_DONE  in  1  memory calibration done, synchronous to CLK.
- SOFT_RST_REQ  in  1  one-cycle soft reset request.
- RST_X_O  out  NDOM  active-low domain resets; bit 0 is the memory controller domain.
- BUSY  out  1  high while any domain is held or sequencing.
- CAL_ERR  out  1  sticky calibration timeout flag.

Function
REQ-006 SHALL pass LOCKED through a two-flop synchronizer; lk_s denotes its output; all lock decisions SHALL use lk_s only.
REQ-007 SHALL implement states HOLD, REL0, WCAL, RELK, RUN; RELK SHALL carry stage index k in 1..NDOM-1.
REQ-008 HOLD: all RST_X_O=0; lk_cnt increments each cycle lk_s=1 and clears when lk_s=0; on the edge where lk_s=1 and lk_cnt==LOCK_FILT-1, go to REL0 with dly_cnt=0.
REQ-009 REL0: dly_cnt increments each cycle; on the edge where dly_cnt==DLY-1, RST_X_O[0] becomes 1, dly_cnt clears, and the state goes to WCAL with cal_cnt=0.
REQ-010 WCAL: when CALIB_DONE=1, go to RELK with k=1 and dly_cnt=0; otherwise cal_cnt increments; on cal_cnt==CAL_TO-1, CAL_ERR becomes 1 and the state goes to HOLD with all RST_X_O=0.
REQ-011 RELK: on the edge where dly_cnt==DLY-1, RST_X_O[k] becomes 1; if k==NDOM-1, go to RUN; else k increments and dly_cnt clears.
REQ-012 RUN: all RST_X_O=1, BUSY=0; SOFT_RST_REQ=1 SHALL, on that edge, clear RST_X_O[NDOM-1:1], keep RST_X_O[0]=1, and enter RELK with k=1 and dly_cnt=0.
REQ-013 SOFT_RST_REQ outside RUN SHALL be ignored and not queued.
REQ-014 lk_s=0 in any state other than HOLD SHALL, on that edge, force HOLD with all RST_X_O=0 and lk_cnt=dly_cnt=cal_cnt=0; CAL_ERR is unchanged.
REQ-015 Priority when events coincide SHALL be: RST > lock loss > calibration timeout > SOFT_RST_REQ > normal progression.
REQ-016 RST_X_O SHALL always be thermometer-coded: RST_X_O[j]=1 implies RST_X_O[i]=1 for all i<j.
REQ-017 BUSY SHALL be 1 in every state except RUN; all outputs SHALL be registered.
REQ-018 Counter widths SHALL be sized by clog2 of their limits; no counter SHALL wrap past its terminal value.
REQ-019 With LOCKED stable high from edge 0, RST_X_O[0] SHALL rise after edge 1+LOCK_FILT+DLY.
REQ-020 Each RST_X_O[k], k>=1, SHALL rise exactly DLY edges after the edge that entered RELK for stage k.

Reset
REQ-021 RST=1 SHALL, on the next edge, set state=HOLD, RST_X_O=0, BUSY=1, CAL_ERR=0, all counters 0, and both synchronizer flops 0.
REQ-022 RST asserted mid-sequence or in RUN SHALL override all other inputs; after RST falls, sequencing restarts from HOLD with no retained lock-filter progress.

Verification
REQ-023 Use LOCK_FILT=4, DLY=8, NDOM=4, CAL_TO=64; LOCKED high from edge 0 and CALIB_DONE=1 at edge 20 -> RST_X_O[0] rises after edge 13; RST_X_O[1] after edge 28; RST_X_O[2] after edge 36; RST_X_O[3] after edge 44; BUSY=0 from edge 44.
REQ-024 Same setup, but LOCKED glitches low for 1 cycle at edge 2 -> lk_cnt restarts and every release shifts later by the glitch-recovery delay; no RST_X_O change before filter completion.
REQ-025 CALIB_DONE held 0 -> CAL_ERR=1 and RST_X_O=4'b0000 exactly 64 edges after WCAL entry; the sequence then retries from HOLD while CAL_ERR stays 1.
REQ-026 In RUN, pulse SOFT_RST_REQ -> next edge RST_X_O=4'b0001, BUSY=1; RST_X_O=4'b1111 again 24 edges later; a second pulse during sequencing has no effect.
REQ-027 In RUN, drop LOCKED -> RST_X_O=0 within 3 edges; assert RST in the middle of REL0 -> all outputs reach reset values on the next edge; the thermometer invariant is checked every cycle.

Source files
------------

// File: rtl/rst_seq.sv
// Power-up reset sequencer: filters PLL lock, releases the memory domain, waits for
// calibration, then releases the remaining domains one stage at a time.
module rst_seq #(
    parameter int NDOM      = 4,
    parameter int LOCK_FILT = 16,
    parameter int DLY       = 128,
    parameter int CAL_TO    = 1048576
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            LOCKED,
    input  logic            CALIB_DONE,
    input  logic            SOFT_RST_REQ,
    output logic [NDOM-1:0] RST_X_O,
    output logic            BUSY,
    output logic            CAL_ERR
);

    localparam int LK_W  = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
    localparam int DLY_W = (DLY > 1) ? $clog2(DLY) : 1;
    localparam int CAL_W = (CAL_TO > 1) ? $clog2(CAL_TO) : 1;
    localparam int K_W   = $clog2(NDOM);

    localparam logic [LK_W-1:0]  LK_LAST  = LK_W'(LOCK_FILT - 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DLY - 1);
    localparam logic [CAL_W-1:0] CAL_LAST = CAL_W'(CAL_TO - 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(NDOM - 1);
    localparam logic [NDOM-1:0]  DOM0_ONLY = {{(NDOM-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_HOLD,
        S_REL0,
        S_WCAL,
        S_RELK,
        S_RUN
    } state_t;

    state_t           state_reg;
    logic [1:0]       sync_reg;
    logic [LK_W-1:0]  lk_cnt_reg;
    logic [DLY_W-1:0] dly_cnt_reg;
    logic [CAL_W-1:0] cal_cnt_reg;
    logic [K_W-1:0]   k_reg;
    logic [NDOM-1:0]  rst_x_reg;
    logic             busy_reg;
    logic             cal_err_reg;
    logic             lk_s;
    logic [NDOM-1:0]  upto_k;

    assign lk_s = sync_reg[1];

    // Releasing stage k always loads a full thermometer pattern, so the output
    // can never hold a gap even if the stage index were corrupted.
    generate
        for (genvar gi = 0; gi < NDOM; gi++) begin : g_upto
            assign upto_k[gi] = (K_W'(gi) <= k_reg);
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= S_HOLD;
            sync_reg    <= 2'b00;
            lk_cnt_reg  <= '0;
            dly_cnt_reg <= '0;
            cal_cnt_reg <= '0;
            k_reg       <= '0;
            rst_x_reg   <= '0;
            busy_reg    <= 1'b1;
            cal_err_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], LOCKED};
            if (state_reg != S_HOLD && !lk_s) begin
                state_reg   <= S_HOLD;
                lk_cnt_reg  <= '0;
                dly_cnt_reg <= '0;
                cal_cnt_reg <= '0;
                k_reg       <= '0;
                rst_x_reg   <= '0;
                busy_reg    <= 1'b1;
            end else begin
                case (state_reg)
                    S_HOLD: begin
                        rst_x_reg <= '0;
                        busy_reg  <= 1'b1;
                        if (!lk_s) begin
                            lk_cnt_reg <= '0;
                        end else if (lk_cnt_reg == LK_LAST) begin
                            lk_cnt_reg  <= '0;
                            dly_cnt_reg <= '0;
                            state_reg   <= S_REL0;
                        end else begin
                            lk_cnt_reg <= lk_cnt_reg + LK_W'(1);
                        end
                    end
                    S_REL0: begin
                        if (dly_cnt_reg == DLY_LAST) begin
                            rst_x_reg   <= DOM0_ONLY;
                            dly_cnt_reg <= '0;
                            cal_cnt_reg <= '0;
                            state_reg   <= S_WCAL;
                        end else begin
                            dly_cnt_reg <= dly_cnt_reg + DLY_W'(1);
                        end
                    end
                    S_WCAL: begin
                        if (CALIB_DONE) begin
                            k_reg       <= K_W'(1);
                            dly_cnt_reg <= '0;
                            state_reg   <= S_RELK;
                        end else if (cal_cnt_reg == CAL_LAST) begin
                            // Timeout drops the memory domain too and retries from lock filtering.
                            cal_err_reg <= 1'b1;
                            rst_x_reg   <= '0;
                            cal_cnt_reg <= '0;
                            lk_cnt_reg  <= '0;
                            state_reg   <= S_HOLD;
                        end else begin
                            cal_cnt_reg <= cal_cnt_reg + CAL_W'(1);
                        end
                    end
                    S_RELK: begin
                        if (dly_cnt_reg == DLY_LAST) begin
                            rst_x_reg   <= upto_k;
                            dly_cnt_reg <= '0;
                            if (k_reg == K_LAST) begin
                                state_reg <= S_RUN;
                                busy_reg  <= 1'b0;
                            end else begin
                                k_reg <= k_reg + K_W'(1);
                            end
                        end else begin
                            dly_cnt_reg <= dly_cnt_reg + DLY_W'(1);
                        end
                    end
                    S_RUN: begin
                        if (SOFT_RST_REQ) begin
                            rst_x_reg   <= DOM0_ONLY;
                            busy_reg    <= 1'b1;
                            k_reg       <= K_W'(1);
                            dly_cnt_reg <= '0;
                            state_reg   <= S_RELK;
                        end
                    end
                    default: begin
                        state_reg <= S_HOLD;
                        rst_x_reg <= '0;
                        busy_reg  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign RST_X_O = rst_x_reg;
    assign BUSY    = busy_reg;
    assign CAL_ERR = cal_err_reg;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: nominal release table plus glitch, timeout,
// soft-reset, lock-loss and mid-sequence reset scenarios.
module tb_rst_seq;

    logic       CLK = 1'b0;
    logic       RST;
    logic       LOCKED;
    logic       CALIB_DONE;
    logic       SOFT_RST_REQ;
    logic [3:0] RST_X_O;
    logic       BUSY;
    logic       CAL_ERR;

    int checks = 0;
    int errors = 0;
    int ed     = -1;

    always #5 CLK = ~CLK;

    rst_seq #(
        .NDOM      (4),
        .LOCK_FILT (4),
        .DLY       (8),
        .CAL_TO    (64)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .LOCKED       (LOCKED),
        .CALIB_DONE   (CALIB_DONE),
        .SOFT_RST_REQ (SOFT_RST_REQ),
        .RST_X_O      (RST_X_O),
        .BUSY         (BUSY),
        .CAL_ERR      (CAL_ERR)
    );

    typedef struct {
        int         at;
        logic [3:0] rx;
        logic       busy;
        logic       cerr;
    } vec_t;

    localparam int NV = 12;
    vec_t nom [NV];

    task automatic check_out(input string name, input logic [3:0] rx,
                             input logic b, input logic ce);
        checks++;
        if (RST_X_O !== rx || BUSY !== b || CAL_ERR !== ce) begin
            errors++;
            $display("FAIL %s edge %0d: got rst_x=%b busy=%b cal_err=%b, expected rst_x=%b busy=%b cal_err=%b",
                     name, ed, RST_X_O, BUSY, CAL_ERR, rx, b, ce);
        end else begin
            $display("ok   %s edge %0d: rst_x=%b busy=%b cal_err=%b", name, ed, RST_X_O, BUSY, CAL_ERR);
        end
    endtask

    // One clock edge; outputs are then sampled on the falling edge and the
    // thermometer shape of RST_X_O is verified every cycle.
    task automatic tick();
        logic [3:0] nxt;
        @(posedge CLK);
        ed++;
        @(negedge CLK);
        nxt = RST_X_O + 4'd1;
        checks++;
        if ((RST_X_O & nxt) !== 4'b0000) begin
            errors++;
            $display("FAIL thermometer edge %0d: got rst_x=%b, expected a thermometer code", ed, RST_X_O);
        end
    endtask

    task automatic run_to(input int target, input int cal_at);
        while (ed < target) begin
            CALIB_DONE = (cal_at >= 0) && (ed + 1 >= cal_at);
            tick();
        end
    endtask

    // Reset with LOCKED already high; the next rising edge becomes edge 0.
    task automatic do_reset();
        RST          = 1'b1;
        LOCKED       = 1'b1;
        CALIB_DONE   = 1'b0;
        SOFT_RST_REQ = 1'b0;
        repeat (3) tick();
        check_out("reset", 4'b0000, 1'b1, 1'b0);
        RST = 1'b0;
        ed  = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 100000 ns");
        $fatal(1);
    end

    initial begin
        nom[0]  = '{4,  4'b0000, 1'b1, 1'b0};
        nom[1]  = '{12, 4'b0000, 1'b1, 1'b0};
        nom[2]  = '{13, 4'b0001, 1'b1, 1'b0};
        nom[3]  = '{20, 4'b0001, 1'b1, 1'b0};
        nom[4]  = '{27, 4'b0001, 1'b1, 1'b0};
        nom[5]  = '{28, 4'b0011, 1'b1, 1'b0};
        nom[6]  = '{35, 4'b0011, 1'b1, 1'b0};
        nom[7]  = '{36, 4'b0111, 1'b1, 1'b0};
        nom[8]  = '{43, 4'b0111, 1'b1, 1'b0};
        nom[9]  = '{44, 4'b1111, 1'b0, 1'b0};
        nom[10] = '{47, 4'b1111, 1'b0, 1'b0};
        nom[11] = '{50, 4'b1111, 1'b0, 1'b0};

        // Nominal power-up with calibration done at edge 20.
        do_reset();
        for (int i = 0; i < NV; i++) begin
            run_to(nom[i].at, 20);
            check_out($sformatf("nominal[%0d]", i), nom[i].rx, nom[i].busy, nom[i].cerr);
        end

        // Soft reset from RUN; extra pulses while sequencing must be dropped.
        SOFT_RST_REQ = 1'b1;
        tick();
        SOFT_RST_REQ = 1'b0;
        check_out("soft_first", 4'b0001, 1'b1, 1'b0);
        run_to(54, 20);
        SOFT_RST_REQ = 1'b1;
        tick();
        SOFT_RST_REQ = 1'b0;
        check_out("soft_ignored_a", 4'b0001, 1'b1, 1'b0);
        run_to(59, 20);
        check_out("soft_stage1", 4'b0011, 1'b1, 1'b0);
        SOFT_RST_REQ = 1'b1;
        tick();
        SOFT_RST_REQ = 1'b0;
        check_out("soft_ignored_b", 4'b0011, 1'b1, 1'b0);
        run_to(74, 20);
        check_out("soft_stage2", 4'b0111, 1'b1, 1'b0);
        run_to(75, 20);
        check_out("soft_done", 4'b1111, 1'b0, 1'b0);
        run_to(80, 20);
        check_out("soft_not_queued", 4'b1111, 1'b0, 1'b0);

        // Lock loss in RUN, sampled low from edge 81.
        LOCKED = 1'b0;
        run_to(83, 20);
        check_out("lock_loss", 4'b0000, 1'b1, 1'b0);
        run_to(90, 20);
        check_out("lock_loss_held", 4'b0000, 1'b1, 1'b0);

        // Calibration never completes: timeout 64 edges after WCAL entry (edge 13).
        do_reset();
        run_to(76, -1);
        check_out("cal_wait", 4'b0001, 1'b1, 1'b0);
        run_to(77, -1);
        check_out("cal_timeout", 4'b0000, 1'b1, 1'b1);
        run_to(80, -1);
        check_out("cal_retry_hold", 4'b0000, 1'b1, 1'b1);
        run_to(88, -1);
        check_out("cal_retry_rel0", 4'b0000, 1'b1, 1'b1);
        run_to(89, -1);
        check_out("cal_retry_dom0", 4'b0001, 1'b1, 1'b1);
        run_to(153, -1);
        check_out("cal_timeout_2", 4'b0000, 1'b1, 1'b1);

        // RST in the middle of the retry's REL0 stage (REL0 entered at edge 157).
        run_to(159, -1);
        check_out("pre_rst_rel0", 4'b0000, 1'b1, 1'b1);
        RST = 1'b1;
        tick();
        check_out("rst_mid_rel0", 4'b0000, 1'b1, 1'b0);
        RST = 1'b0;
        ed  = -1;
        run_to(12, 20);
        check_out("restart_pre", 4'b0000, 1'b1, 1'b0);
        run_to(13, 20);
        check_out("restart_dom0", 4'b0001, 1'b1, 1'b0);
        run_to(28, 20);
        check_out("restart_dom1", 4'b0011, 1'b1, 1'b0);

        // One-cycle LOCKED glitch at edge 2 delays everything by three edges.
        do_reset();
        run_to(1, 23);
        LOCKED = 1'b0;
        tick();
        LOCKED = 1'b1;
        run_to(13, 23);
        check_out("glitch_no_early", 4'b0000, 1'b1, 1'b0);
        run_to(15, 23);
        check_out("glitch_pre", 4'b0000, 1'b1, 1'b0);
        run_to(16, 23);
        check_out("glitch_dom0", 4'b0001, 1'b1, 1'b0);
        run_to(30, 23);
        check_out("glitch_pre_dom1", 4'b0001, 1'b1, 1'b0);
        run_to(31, 23);
        check_out("glitch_dom1", 4'b0011, 1'b1, 1'b0);
        run_to(47, 23);
        check_out("glitch_run", 4'b1111, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
